// File: rtl/mcore_bitwriter_pkg.sv
// mcore_defs: shared definitions for the mcore bit writer.
//   bw_op_e       - command opcodes on cmd_op
//   BW_MAX_WIDTH  - widest field a single WRITE may carry
//   BW_REG_*      - register window offsets, mirroring the bit reader layout
package mcore_defs;

  typedef enum logic [1:0] {
    BW_ATTACH = 2'd0,
    BW_WRITE  = 2'd1,
    BW_FLUSH  = 2'd2,
    BW_NOP    = 2'd3
  } bw_op_e;

  localparam int unsigned BW_MAX_WIDTH = 32;

  localparam logic [31:0] M_UTIL_ADDR   = 32'h0000_0400;
  localparam logic [31:0] BW_REG_CTRL   = M_UTIL_ADDR + 32'h10;
  localparam logic [31:0] BW_REG_DATA   = M_UTIL_ADDR + 32'h14;
  localparam logic [31:0] BW_REG_COUNT  = M_UTIL_ADDR + 32'h18;
  localparam logic [31:0] BW_REG_STATUS = M_UTIL_ADDR + 32'h1c;

endpackage

// File: rtl/mcore_bitwriter_pack.sv
// mcore_bitwriter_pack: combinational field insert and flush byte enables.
//   acc      in  64  pending bits, left-aligned at bit 63
//   fill     in  7   number of valid bits in acc (0..31 when used here)
//   data     in  32  field, right-aligned
//   width    in  6   field width, 0..32 (larger values are ignored by caller)
//   acc_next out 64  acc with the field placed at acc[63-fill -: width]
//   be       out 4   byte enables covering ceil(fill/8) bytes from the MSB
module mcore_bitwriter_pack (
  input  logic [63:0] acc,
  input  logic [6:0]  fill,
  input  logic [31:0] data,
  input  logic [5:0]  width,
  output logic [63:0] acc_next,
  output logic [3:0]  be
);

  logic [31:0] field;
  logic [2:0]  nbytes;

  always_comb begin
    // Left-aligning the field also discards the bits above width.
    field    = data << (6'd32 - width);
    acc_next = acc | ({field, 32'b0} >> fill);
    nbytes   = 3'((fill + 7'd7) >> 3);
    be       = 4'hF << (3'd4 - nbytes);
  end

endmodule

// File: rtl/mcore_bitwriter.sv
// mcore_bitwriter: packs 1..32-bit fields MSB-first into 32-bit words and
// writes each completed word (or a zero-padded final word on FLUSH) to memory.
//   aclk, aresetn                 clock, synchronous active-low reset
//   cmd_valid/ready/op/width/data command port (ATTACH, WRITE, FLUSH, NOP)
//   busy, bit_count, err          status
//   mem_req/addr/we/wdata/be      memory write request, held until mem_gnt
//   mem_gnt, mem_rsp_valid/error  memory handshake and write response
module mcore_bitwriter
  import mcore_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [5:0]              cmd_width,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    busy,
  output logic [31:0]             bit_count,
  output logic                    err,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rsp_valid,
  input  logic                    mem_rsp_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR_REQ = 2'd1;
  localparam logic [1:0] S_WR_RSP = 2'd2;

  logic [1:0]            state;
  logic [63:0]           acc;
  logic [6:0]            fill;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  flushing;

  logic [63:0] acc_ins;
  logic [3:0]  be_flush;
  logic [6:0]  fill_ins;
  logic        cmd_fire;

  mcore_bitwriter_pack u_pack (
    .acc      (acc),
    .fill     (fill),
    .data     (cmd_data[31:0]),
    .width    (cmd_width),
    .acc_next (acc_ins),
    .be       (be_flush)
  );

  assign fill_ins = fill + {1'b0, cmd_width};
  assign cmd_fire = cmd_valid && cmd_ready;
  assign busy     = (state != S_IDLE);
  assign mem_we   = mem_req;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      acc       <= '0;
      fill      <= '0;
      wr_addr   <= '0;
      flushing  <= 1'b0;
      bit_count <= '0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            case (bw_op_e'(cmd_op))
              BW_ATTACH: begin
                wr_addr   <= ADDR_WIDTH'(cmd_data) & ~ADDR_WIDTH'(3);
                acc       <= '0;
                fill      <= '0;
                bit_count <= '0;
                err       <= 1'b0;
              end
              BW_WRITE: begin
                if (32'(cmd_width) > BW_MAX_WIDTH) begin
                  err <= 1'b1;
                end else if (cmd_width != 6'd0) begin
                  acc       <= acc_ins;
                  fill      <= fill_ins;
                  bit_count <= bit_count + 32'(cmd_width);
                  if (fill_ins >= 7'd32) begin
                    state     <= S_WR_REQ;
                    cmd_ready <= 1'b0;
                    flushing  <= 1'b0;
                    mem_req   <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= acc_ins[63:32];
                    mem_be    <= 4'hF;
                  end
                end
              end
              BW_FLUSH: begin
                if (fill != 7'd0) begin
                  state     <= S_WR_REQ;
                  cmd_ready <= 1'b0;
                  flushing  <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_addr  <= wr_addr;
                  mem_wdata <= acc[63:32];
                  mem_be    <= be_flush;
                end
              end
              default: ;
            endcase
          end
        end
        S_WR_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WR_RSP;
          end
        end
        S_WR_RSP: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_error) err <= 1'b1;
            wr_addr   <= wr_addr + ADDR_WIDTH'(4);
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            if (flushing) begin
              acc  <= '0;
              fill <= '0;
            end else begin
              acc  <= {acc[31:0], 32'b0};
              fill <= fill - 7'd32;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcore_bitwriter.sv
module tb_mcore_bitwriter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd3;
  logic [5:0]  cmd_width = '0;
  logic [31:0] cmd_data = '0;
  logic        busy;
  logic [31:0] bit_count;
  logic        err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic        mem_rsp_error = 1'b0;

  int checks = 0;
  int errors = 0;

  mcore_bitwriter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_width     (cmd_width),
    .cmd_data      (cmd_data),
    .busy          (busy),
    .bit_count     (bit_count),
    .err           (err),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_gnt       (mem_gnt),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_error (mem_rsp_error)
  );

  always #5 aclk = ~aclk;

  // Issue one command; returns at the negedge after acceptance.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] w, input logic [31:0] d);
    int n = 0;
    @(negedge aclk);
    while (!cmd_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_width = w; cmd_data = d;
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_op = 2'd3; cmd_width = '0; cmd_data = '0;
  endtask

  // Wait for a request, check it, grant after gnt_delay cycles, then respond.
  task automatic serve_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input int gnt_delay, input logic rerr);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mem_req_timeout: mem_req=%b required 1", mem_req);
      return;
    end
    checks++;
    if (mem_addr !== a) begin errors++; $display("FAIL mem_addr: got %h required %h", mem_addr, a); end
    checks++;
    if (mem_wdata !== d) begin errors++; $display("FAIL mem_wdata: got %h required %h", mem_wdata, d); end
    checks++;
    if (mem_be !== be) begin errors++; $display("FAIL mem_be: got %b required %b", mem_be, be); end
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL mem_we: got %b required 1", mem_we); end
    for (int i = 0; i < gnt_delay; i++) begin
      @(negedge aclk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a || mem_wdata !== d || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d req=%b addr=%h data=%h ready=%b required 1/%h/%h/0",
                 i, mem_req, mem_addr, mem_wdata, cmd_ready, a, d);
      end
    end
    mem_gnt = 1'b1;
    @(negedge aclk);
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_grant: mem_req=%b busy=%b required 0/1", mem_req, busy);
    end
    @(negedge aclk);
    mem_rsp_valid = 1'b1; mem_rsp_error = rerr;
    @(negedge aclk);
    mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_rsp: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || bit_count !== 32'd0 || err !== 1'b0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b cnt=%0d err=%b req=%b we=%b wdata=%h be=%b required all 0",
               tag, cmd_ready, busy, bit_count, err, mem_req, mem_we, mem_wdata, mem_be);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset_values");
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", cmd_ready); end
  endtask

  task automatic test_words();
    do_cmd(2'd0, 6'd0, 32'h000a_8f78);
    // A response while IDLE must be ignored.
    mem_rsp_valid = 1'b1; mem_rsp_error = 1'b1;
    @(negedge aclk);
    mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL idle_rsp_ignored: err=%b required 0", err); end
    do_cmd(2'd1, 6'd8, 32'h02);
    do_cmd(2'd1, 6'd8, 32'h40);
    do_cmd(2'd1, 6'd8, 32'h9f);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL early_req: mem_req=%b required 0", mem_req); end
    do_cmd(2'd1, 6'd8, 32'h96);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b required 0", cmd_ready); end
    serve_write(32'h000a_8f78, 32'h0240_9f96, 4'hF, 0, 1'b0);
    checks++;
    if (bit_count !== 32'd32) begin errors++; $display("FAIL bit_count_32: got %0d required 32", bit_count); end
    repeat (2) @(negedge aclk);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL extra_write: mem_req=%b required 0", mem_req); end
    do_cmd(2'd1, 6'd3, 32'h5);
    do_cmd(2'd2, 6'd0, 32'h0);
    serve_write(32'h000a_8f7c, 32'hA000_0000, 4'b1000, 0, 1'b0);
    checks++;
    if (bit_count !== 32'd35) begin errors++; $display("FAIL bit_count_35: got %0d required 35", bit_count); end
  endtask

  task automatic test_crossing();
    do_cmd(2'd0, 6'd0, 32'h0000_1000);
    do_cmd(2'd1, 6'd28, 32'h0ABC_DEF1);
    do_cmd(2'd1, 6'd8, 32'h5A);
    serve_write(32'h0000_1000, 32'hABCD_EF15, 4'hF, 0, 1'b0);
    do_cmd(2'd2, 6'd0, 32'h0);
    serve_write(32'h0000_1004, 32'hA000_0000, 4'b1000, 0, 1'b0);
    checks++;
    if (bit_count !== 32'd36) begin errors++; $display("FAIL bit_count_36: got %0d required 36", bit_count); end
  endtask

  task automatic test_stall_error();
    do_cmd(2'd0, 6'd0, 32'h0000_2002);
    do_cmd(2'd1, 6'd32, 32'hDEAD_BEEF);
    serve_write(32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 10, 1'b1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL rsp_err: err=%b required 1", err); end
    do_cmd(2'd1, 6'd32, 32'h1234_5678);
    serve_write(32'h0000_2004, 32'h1234_5678, 4'hF, 0, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b required 1", err); end
    do_cmd(2'd0, 6'd0, 32'h0000_3000);
    checks++;
    if (err !== 1'b0 || bit_count !== 32'd0) begin
      errors++; $display("FAIL attach_clear: err=%b cnt=%0d required 0/0", err, bit_count);
    end
  endtask

  task automatic test_illegal_widths();
    do_cmd(2'd1, 6'd4, 32'hF);
    do_cmd(2'd1, 6'd0, 32'hFFFF_FFFF);
    checks++;
    if (bit_count !== 32'd4 || err !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL width0_noop: cnt=%0d err=%b busy=%b req=%b required 4/0/0/0",
                         bit_count, err, busy, mem_req);
    end
    do_cmd(2'd1, 6'd40, 32'hFFFF_FFFF);
    checks++;
    if (err !== 1'b1 || bit_count !== 32'd4 || mem_req !== 1'b0) begin
      errors++; $display("FAIL width40_err: err=%b cnt=%0d req=%b required 1/4/0", err, bit_count, mem_req);
    end
    do_cmd(2'd1, 6'd28, 32'h0123_4567);
    serve_write(32'h0000_3000, 32'hF123_4567, 4'hF, 0, 1'b0);
    do_cmd(2'd2, 6'd0, 32'h0);
    repeat (3) begin
      @(negedge aclk);
      checks++;
      if (mem_req !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL flush_empty: req=%b ready=%b required 0/1", mem_req, cmd_ready);
      end
    end
    do_cmd(2'd3, 6'd0, 32'h0);
    checks++;
    if (mem_req !== 1'b0 || bit_count !== 32'd32) begin
      errors++; $display("FAIL nop: req=%b cnt=%0d required 0/32", mem_req, bit_count);
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    do_cmd(2'd0, 6'd0, 32'h0000_4000);
    do_cmd(2'd1, 6'd32, 32'hCAFE_F00D);
    while (!mem_req && n < 20) begin @(negedge aclk); n++; end
    mem_gnt = 1'b1;
    @(negedge aclk);
    mem_gnt = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL in_wr_rsp: busy=%b req=%b required 1/0", busy, mem_req);
    end
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset_outputs("reset_mid_write");
    aresetn = 1'b1;
    do_cmd(2'd0, 6'd0, 32'h0000_5000);
    do_cmd(2'd1, 6'd32, 32'h0BAD_C0DE);
    serve_write(32'h0000_5000, 32'h0BAD_C0DE, 4'hF, 0, 1'b0);
    checks++;
    if (bit_count !== 32'd32 || err !== 1'b0) begin
      errors++; $display("FAIL after_reset_write: cnt=%0d err=%b required 32/0", bit_count, err);
    end
  endtask

  initial begin
    test_reset();
    test_words();
    test_crossing();
    test_stall_error();
    test_illegal_widths();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mcore_bitwriter.md
# mcore_bitwriter

Bit-packing writer: the write-side counterpart of the MADAM bit reader. It accepts variable-width fields of 1..32 bits, packs them MSB-first into 32-bit words and stores each completed word through the `mem_if` master port to PS memory. A `FLUSH` command writes a final partial word, zero-padded, with byte enables. It sits beside the bit reader in `mcore_top`, is driven by the mcore command logic, and shares the memory arbiter.

## Interface
Parameters:
- DATA_WIDTH, 32, memory data width; only 32 is supported.
- ADDR_WIDTH, 32, memory byte-address width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset: synchronous, active-low; clock aclk.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command opcode: ATTACH=0, WRITE=1, FLUSH=2, NOP=3.
- cmd_width  in  6  field width in bits for WRITE.
- cmd_data  in  DATA_WIDTH  WRITE field, right-aligned; ATTACH base address.
- busy  out  1  high while not in IDLE.
- bit_count  out  32  total bits accepted since the last ATTACH.
- err  out  1  sticky error flag; cleared by ATTACH.
- mem_req  out  1  memory request.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_we  out  1  always 1 while mem_req is high.
- mem_wdata  out  DATA_WIDTH  packed word.
- mem_be  out  DATA_WIDTH/8  byte enables.
- mem_gnt  in  1  request accepted.
- mem_rsp_valid  in  1  write response.
- mem_rsp_error  in  1  response error, qualified by mem_rsp_valid.

## Operation
- State: `acc[63:0]` holds pending bits, left-aligned at bit 63; `fill` (0..63) counts valid bits; `wr_addr` is the next word address.
- ATTACH: `wr_addr <= cmd_data & ~3`; clears acc, fill, bit_count and err. Any pending bits are discarded.
- WRITE with w = cmd_width, where 1 ≤ w ≤ 32: inserts cmd_data[w-1:0] at acc[63-fill -: w]; `fill += w`; `bit_count += w`. Bits above w are ignored.
- WRITE with w = 0 is a no-op. WRITE with w > 32 sets err and is dropped.
- When fill ≥ 32 after a WRITE, the FSM enters WR_REQ with wdata = acc[63:32] and be = 4'hF. After the response it does `acc <<= 32` and `fill -= 32`.
- FLUSH with fill = 0 is a no-op. FLUSH with fill > 0 writes acc[63:32] (low bits already zero) with be[3-i] = 1 for each byte i < ceil(fill/8); then it clears acc and fill.
- Byte 0 of the stream goes to the MSB byte (be[3]), which matches the bit reader's MSB-first consumption.
- FSM states:
  - IDLE: cmd_ready = 1. Accepts a command, then goes to WR_REQ if a word is due, else stays in IDLE.
  - WR_REQ: mem_req = 1. Goes to WR_RSP on mem_gnt.
  - WR_RSP: waits for mem_rsp_valid. mem_rsp_error sets err. Then `wr_addr += 4` and the FSM returns to IDLE.
- wr_addr wraps modulo 2^ADDR_WIDTH; no fault is raised.
- Arithmetic: fill is 7 bits wide, its maximum is 31 + 32 = 63, and it cannot overflow. bit_count wraps at 2^32.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after; busy=0, bit_count=0, err=0, mem_req=0, mem_we=0, mem_wdata=0, mem_be=0. Reset mid-transaction drops mem_req on the next edge and discards all state.
- Each command takes 1 cycle in IDLE. cmd_ready is registered and falls the cycle after a word-producing command.
- mem_req, mem_addr, mem_wdata and mem_be are registered and held stable until mem_gnt is sampled high. mem_req deasserts the cycle after the grant.
- mem_gnt may arrive in the same cycle mem_req rises. mem_rsp_valid comes at least 1 cycle after the grant.
- Minimum WRITE→mem_req latency is 1 cycle. Minimum time to the next accepted command is 3 cycles plus the memory latency.
- mem_rsp_valid received while in IDLE or WR_REQ is ignored.

## Structure
- `mcore_defs` package:
  - `bw_op_e` enum (ATTACH/WRITE/FLUSH/NOP).
  - `BW_MAX_WIDTH = 32`.
  - Register offsets for the bitwriter window at `M_UTIL_ADDR + 0x10..0x1c`, mirroring the bit reader layout.
- One sub-module, `mcore_bitwriter_pack`: a combinational insert of cmd_data into acc at position fill, plus byte-enable generation from fill. The FSM and counters stay in `mcore_bitwriter`.

## Test plan
- Words issued on fill: ATTACH 0xa8f78, then WRITE w8 0x02, w8 0x40, w8 0x9f, w8 0x96 → exactly one write to 0xa8f78 with data 0x02409f96 and be 4'hF; bit_count = 32.
- Partial flush: then WRITE w3 0x5 and FLUSH → write to 0xa8f7c with data 0xA0000000 and be 4'b1000.
- Word crossing: ATTACH 0x1000, WRITE w28 0xABCDEF1, then w8 0x5A → write to 0x1000 with data 0xABCDEF15; FLUSH → write to 0x1004 with data 0xA0000000 and be 4'b1000.
- Stalled grant and error: hold mem_gnt low for 10 cycles → mem_req, mem_addr and mem_wdata stay stable and cmd_ready stays 0. A response with mem_rsp_error=1 → err=1 and wr_addr still advances by 4; the next ATTACH clears err.
- Illegal widths: WRITE w0 → no state change; WRITE w40 → err=1 and fill unchanged. FLUSH with fill=0 → no memory request.
- Reset mid-write: drop aresetn while in WR_RSP → all outputs reach their reset values on the next edge; after release, ATTACH plus a 32-bit WRITE works normally.
